// File: rtl/uart_pkg.sv
// Shared UART TX definitions: FSM state encoding, parity selectors and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Data-bit index counter width; covers DATA_WIDTH up to 9.
  localparam int unsigned BIT_CNT_W = 4;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX word FIFO; pointers carry an extra wrap bit to tell full from empty.
module uart_tx_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       i_push,
  input  logic [DATA_WIDTH-1:0]      i_wdata,
  input  logic                       i_pop,
  output logic [DATA_WIDTH-1:0]      o_rdata,
  output logic                       o_empty,
  output logic                       o_ready,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic                  r_ready;
  logic [AW:0]           w_wr_nxt;
  logic [AW:0]           w_rd_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full_nxt;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_push     = i_push && r_ready;
  assign w_pop      = i_pop && !o_empty;
  assign w_wr_nxt   = w_push ? r_wr_ptr + (AW + 1)'(1) : r_wr_ptr;
  assign w_rd_nxt   = w_pop ? r_rd_ptr + (AW + 1)'(1) : r_rd_ptr;
  assign w_full_nxt = (w_wr_nxt[AW] != w_rd_nxt[AW]) &&
                      (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ready  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_ready  <= !w_full_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];
  assign o_ready = r_ready;
  assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter. Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO;
// otherwise a single holding register buffers one word.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRESC_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          i_Data_Valid,
  input  logic [DATA_WIDTH-1:0]         i_P_DATA,
  input  logic                          i_PAR_EN,
  input  logic                          i_PAR_TYP,
  input  logic                          i_STP2,
  input  logic [PRESC_WIDTH-1:0]        i_Prescale,
  output logic                          o_ready,
  output logic                          o_TX_OUT,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  logic                  w_pop;
  logic                  w_empty;
  logic [DATA_WIDTH-1:0] w_rdata;

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .i_push  (i_Data_Valid),
    .i_wdata (i_P_DATA),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_ready (o_ready),
    .o_count (o_count)
  );
`else
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_hold_data;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_pop) begin
      r_hold_full <= 1'b0;
    end else if (i_Data_Valid && !r_hold_full) begin
      r_hold_full <= 1'b1;
      r_hold_data <= i_P_DATA;
    end
  end

  assign w_empty = !r_hold_full;
  assign w_rdata = r_hold_data;
  assign o_ready = !r_hold_full;
  assign o_count = {{($clog2(FIFO_DEPTH)){1'b0}}, r_hold_full};
`endif

  uart_state_e            r_state, w_state_nxt;
  logic [PRESC_WIDTH-1:0] r_baud, w_baud_nxt;
  logic [BIT_CNT_W-1:0]   r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0]  r_shift, w_shift_nxt;
  logic [PRESC_WIDTH-1:0] r_presc, w_presc_nxt;
  logic                   r_par_en, w_par_en_nxt;
  logic                   r_stp2, w_stp2_nxt;
  logic                   r_par_bit, w_par_bit_nxt;
  logic                   r_tx, w_tx_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   w_bit_end;
  logic [PRESC_WIDTH-1:0] w_presc_eff;

  assign w_presc_eff = (i_Prescale == '0) ? PRESC_WIDTH'(1) : i_Prescale;
  assign w_bit_end   = (r_baud == r_presc - PRESC_WIDTH'(1));

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_nxt     = r_bit;
    w_shift_nxt   = r_shift;
    w_presc_nxt   = r_presc;
    w_par_en_nxt  = r_par_en;
    w_stp2_nxt    = r_stp2;
    w_par_bit_nxt = r_par_bit;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;
    w_pop         = 1'b0;

    unique case (r_state)
      StIdle: begin
        w_tx_nxt   = IDLE_LEVEL;
        w_busy_nxt = 1'b0;
        w_pop      = !w_empty;
      end
      StStart: begin
        if (w_bit_end) begin
          w_state_nxt = StData;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + PRESC_WIDTH'(1);
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == BIT_CNT_W'(DATA_WIDTH - 1)) begin
            w_bit_nxt = '0;
            if (r_par_en) begin
              w_state_nxt = StParity;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = StStop;
              w_tx_nxt    = STOP_LEVEL;
            end
          end else begin
            w_bit_nxt   = r_bit + BIT_CNT_W'(1);
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end
        end else begin
          w_baud_nxt = r_baud + PRESC_WIDTH'(1);
        end
      end
      StParity: begin
        if (w_bit_end) begin
          w_state_nxt = StStop;
          w_baud_nxt  = '0;
          w_tx_nxt    = STOP_LEVEL;
        end else begin
          w_baud_nxt = r_baud + PRESC_WIDTH'(1);
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_stp2 && (r_bit == '0)) begin
            w_bit_nxt = BIT_CNT_W'(1);
          end else if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_nxt = StIdle;
            w_tx_nxt    = IDLE_LEVEL;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_baud_nxt = r_baud + PRESC_WIDTH'(1);
        end
      end
      default: w_state_nxt = StIdle;
    endcase

    // Frame start: pop the next word and latch the framing configuration for this frame.
    if (w_pop) begin
      w_state_nxt   = StStart;
      w_baud_nxt    = '0;
      w_bit_nxt     = '0;
      w_shift_nxt   = w_rdata;
      w_presc_nxt   = w_presc_eff;
      w_par_en_nxt  = i_PAR_EN;
      w_stp2_nxt    = i_STP2;
      w_par_bit_nxt = (^w_rdata) ^ (i_PAR_TYP == PAR_ODD);
      w_tx_nxt      = START_LEVEL;
      w_busy_nxt    = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= StIdle;
      r_baud    <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      r_presc   <= PRESC_WIDTH'(1);
      r_par_en  <= 1'b0;
      r_stp2    <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= IDLE_LEVEL;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_presc   <= w_presc_nxt;
      r_par_en  <= w_par_en_nxt;
      r_stp2    <= w_stp2_nxt;
      r_par_bit <= w_par_bit_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
    end
  end

  assign o_TX_OUT = r_tx;
  assign o_busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame table, corner sequences, random traffic
// against a queue-based line model.
module tb_uart_tx_buffered;

  localparam int DW = 8;
  localparam int PW = 6;
`ifdef UART_TX_FIFO_EN
  localparam int CAP      = 4;
  localparam int B2B_C0   = 1;
  localparam int B2B_C1   = 1;
  localparam int B2B_C2   = 2;
  localparam int B2B_BUSY = 60;
`else
  localparam int CAP      = 1;
  localparam int B2B_C0   = 1;
  localparam int B2B_C1   = 0;
  localparam int B2B_C2   = 1;
  localparam int B2B_BUSY = 40;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic          vld = 1'b0;
  logic [DW-1:0] pdata = '0;
  logic          pe = 1'b0;
  logic          pt = 1'b0;
  logic          s2 = 1'b0;
  logic [PW-1:0] presc = 6'd1;
  logic          o_ready;
  logic          o_tx;
  logic          o_busy;
  logic [2:0]    o_count;

  always #5 CLK = ~CLK;

  uart_tx_buffered #(
    .DATA_WIDTH  (DW),
    .PRESC_WIDTH (PW),
    .FIFO_DEPTH  (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .i_Data_Valid (vld),
    .i_P_DATA     (pdata),
    .i_PAR_EN     (pe),
    .i_PAR_TYP    (pt),
    .i_STP2       (s2),
    .i_Prescale   (presc),
    .o_ready      (o_ready),
    .o_TX_OUT     (o_tx),
    .o_busy       (o_busy),
    .o_count      (o_count)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words waiting to start, and the expected line value for each cycle.
  logic [DW-1:0] mq_word[$];
  bit            mq_line[$];

  task automatic add_frame(input logic [DW-1:0] w);
    int p;
    bit bits[$];
    p = (presc == 0) ? 1 : int'(presc);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (pe) bits.push_back((^w) ^ pt);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[k]) repeat (p) mq_line.push_back(bits[k]);
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      mq_line.delete();
      mq_word.delete();
    end else begin
      bit acc;
      acc = vld && (mq_word.size() < CAP);
      if (mq_line.size() != 0) void'(mq_line.pop_front());
      if (mq_line.size() == 0 && mq_word.size() != 0) add_frame(mq_word.pop_front());
      if (acc) mq_word.push_back(pdata);
    end
  end

  always @(negedge CLK) begin
    chk("mon_tx", o_tx, (mq_line.size() != 0) ? 32'(mq_line[0]) : 32'd1);
    chk("mon_busy", o_busy, 32'(mq_line.size() != 0));
    chk("mon_count", o_count, mq_word.size());
    chk("mon_ready", o_ready, 32'(mq_word.size() < CAP));
  end

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        s2;
    logic [5:0]  presc;
    logic [11:0] bits;
    int          nbits;
    int          effp;
    int          busy;
  } vec_t;

  vec_t tbl[6];

  task automatic wait_idle();
    int g = 0;
    while ((o_busy || o_count != 0) && g < 2000) begin
      @(negedge CLK);
      g++;
    end
    if (g >= 2000) chk("idle_timeout", 1, 0);
    @(negedge CLK);
  endtask

  task automatic run_vec(input int v);
    int cyc;
    int bad;
    int idx;
    bit s[$];
    wait_idle();
    pe    = tbl[v].pe;
    pt    = tbl[v].pt;
    s2    = tbl[v].s2;
    presc = tbl[v].presc;
    pdata = tbl[v].data;
    vld   = 1'b1;
    @(negedge CLK);
    vld = 1'b0;
    chk($sformatf("tbl%0d_count_after_write", v), o_count, 1);
    chk($sformatf("tbl%0d_idle_before_start", v), o_tx, 1);
    @(negedge CLK);
    chk($sformatf("tbl%0d_start_latency", v), o_tx, 0);
    cyc = 0;
    while (o_busy && cyc < 1000) begin
      s.push_back(o_tx);
      cyc++;
      @(negedge CLK);
    end
    chk($sformatf("tbl%0d_busy_cycles", v), cyc, tbl[v].busy);
    for (int k = 0; k < tbl[v].nbits; k++) begin
      bad = 0;
      for (int j = 0; j < tbl[v].effp; j++) begin
        idx = k * tbl[v].effp + j;
        if (idx >= s.size() || s[idx] !== tbl[v].bits[k]) bad++;
      end
      chk($sformatf("tbl%0d_bit%0d_bad_cycles", v, k), bad, 0);
    end
  endtask

  initial begin
    // data, pe, pt, s2, presc, line bits (bit i = i-th on line), nbits, eff prescale, busy
    tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 6'd4, 12'b0101_0100_1010, 11, 4, 44};
    tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 6'd1, 12'b1110_0000_0000, 12, 1, 12};
    tbl[2] = '{8'hFF, 1'b0, 1'b0, 1'b0, 6'd2, 12'b0011_1111_1110, 10, 2, 20};
    tbl[3] = '{8'h01, 1'b1, 1'b1, 1'b1, 6'd3, 12'b1100_0000_0010, 12, 3, 36};
    tbl[4] = '{8'h80, 1'b0, 1'b0, 1'b0, 6'd0, 12'b0011_0000_0000, 10, 1, 10};
    tbl[5] = '{8'h3C, 1'b1, 1'b0, 1'b1, 6'd2, 12'b1100_0111_1000, 12, 2, 24};

    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset_tx", o_tx, 1);
    chk("reset_busy", o_busy, 0);
    chk("reset_ready", o_ready, 1);
    chk("reset_count", o_count, 0);
    RST = 1'b1;
    @(negedge CLK);

    for (int v = 0; v < 6; v++) run_vec(v);

    // Back-to-back writes on consecutive cycles.
    wait_idle();
    pe = 1'b0; s2 = 1'b0; presc = 6'd2;
    pdata = 8'h11; vld = 1'b1;
    @(negedge CLK);
    chk("b2b_count0", o_count, B2B_C0);
    pdata = 8'h22;
    @(negedge CLK);
    chk("b2b_count1", o_count, B2B_C1);
    pdata = 8'h33;
    @(negedge CLK);
    chk("b2b_count2", o_count, B2B_C2);
    vld = 1'b0;
    begin
      int cyc = 1;
      while (o_busy && cyc < 500) begin
        cyc++;
        @(negedge CLK);
      end
      chk("b2b_gapless_busy", cyc, B2B_BUSY);
    end
    chk("b2b_drained", o_count, 0);

    // Overflow: five writes while a frame is in flight.
    wait_idle();
    presc = 6'd3; pe = 1'b0; s2 = 1'b0;
    pdata = 8'h00; vld = 1'b1;
    @(negedge CLK);
    vld = 1'b0;
    repeat (3) @(negedge CLK);
    for (int k = 1; k <= 5; k++) begin
      int m;
      m = (k < CAP) ? k : CAP;
      pdata = 8'(k); vld = 1'b1;
      @(negedge CLK);
      chk($sformatf("ovf_count_%0d", k), o_count, m);
      chk($sformatf("ovf_ready_%0d", k), o_ready, 32'(m < CAP));
    end
    vld = 1'b0;
    wait_idle();

    // Reset asserted during the data bits of 0xFF with further words queued.
    presc = 6'd2; pe = 1'b1; pt = 1'b0; s2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pdata = (k == 0) ? 8'hFF : 8'(8'h12 + k);
      vld = 1'b1;
      @(negedge CLK);
    end
    vld = 1'b0;
    repeat (4) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("rst_mid_tx", o_tx, 1);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_count", o_count, 0);
    chk("rst_mid_ready", o_ready, 1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (40) @(negedge CLK);
    chk("rst_after_tx", o_tx, 1);
    chk("rst_after_busy", o_busy, 0);

    // Random traffic with framing settings changing every cycle, including mid-frame.
    for (int i = 0; i < 1500; i++) begin
      vld   = ($urandom_range(0, 2) == 0);
      pdata = 8'($urandom);
      pe    = 1'($urandom_range(0, 1));
      pt    = 1'($urandom_range(0, 1));
      s2    = 1'($urandom_range(0, 1));
      presc = 6'($urandom_range(0, 4));
      @(negedge CLK);
    end
    vld = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data bits per frame, legal range 5..9.
REQ-002 Parameter PRESC_WIDTH, default 6: width of the bit-period prescale input.
REQ-003 Parameter FIFO_DEPTH, default 4: TX FIFO entries; power of two, minimum 2.
REQ-004 CLK  in  1: single clock; all logic on rising edge.
REQ-005 RST  in  1: asynchronous, active-low reset.
REQ-006 i_Data_Valid  in  1: write strobe; a word is accepted on a rising edge where i_Data_Valid && o_ready.
REQ-007 i_P_DATA  in  DATA_WIDTH: parallel word to transmit.
REQ-008 i_PAR_EN  in  1: 1 = parity bit inserted after the data bits.
REQ-009 i_PAR_TYP  in  1: 0 = even parity, 1 = odd parity.
REQ-010 i_STP2  in  1: 1 = two stop bits, 0 = one stop bit.
REQ-011 i_Prescale  in  PRESC_WIDTH: CLK cycles per bit; value 0 is treated as 1.
REQ-012 o_ready  out  1: registered; high when a word can be accepted.
REQ-013 o_TX_OUT  out  1: registered serial line; idle high.
REQ-014 o_busy  out  1: registered; high from the first start-bit cycle through the last stop-bit cycle.
REQ-015 o_count  out  clog2(FIFO_DEPTH)+1: number of words stored but not yet started.

Function
REQ-016 Frame format: start (0), data LSB first, optional parity, then 1 or 2 stop bits (1).
REQ-017 Each bit SHALL hold o_TX_OUT for exactly max(i_Prescale,1) CLK cycles, counted by an internal baud counter.
REQ-018 i_PAR_EN, i_PAR_TYP, i_STP2 and i_Prescale SHALL be latched at frame start; changes mid-frame affect only the next frame.
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE->START when FIFO is non-empty (pop).
- START->DATA after one bit period.
- DATA->PARITY after DATA_WIDTH bits if parity is enabled, otherwise DATA->STOP.
- PARITY->STOP after one bit period.
- STOP->START if the FIFO is non-empty at the end of the last stop bit, giving a back-to-back frame with no idle gap; otherwise STOP->IDLE.
REQ-020 Latency: a word accepted at edge N into an empty FIFO while IDLE drives the start bit on o_TX_OUT after edge N+1.
REQ-021 Parity bit: XOR of data bits for even; the inverted XOR for odd.
REQ-022 o_ready SHALL be low when the FIFO is full; writes while o_ready is low SHALL be ignored with no state change.
REQ-023 A simultaneous push and pop SHALL leave o_count unchanged and preserve word order.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-025 While RST=0: o_TX_OUT=1, o_busy=0, o_ready=1, o_count=0, FSM=IDLE, baud counter=0, FIFO pointers=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately and discard all FIFO contents; no partial frame resumes after release.

Configuration
REQ-027 Macro UART_TX_FIFO_EN defined: FIFO of FIFO_DEPTH entries as specified above.
REQ-028 Macro UART_TX_FIFO_EN undefined: single holding register; FIFO_DEPTH is ignored; o_count is 0 or 1; o_ready = !holding_full. All other behaviour is identical.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state encoding, the PAR_EVEN/PAR_ODD constants and the IDLE_LEVEL/START_LEVEL/STOP_LEVEL constants.
REQ-030 The FIFO SHALL be the single sub-module uart_tx_fifo (synchronous, one clock, same reset), instantiated only under UART_TX_FIFO_EN.

Verification
REQ-031 Basic frame: Prescale=4, PAR_EN=1, PAR_TYP=0, STP2=0, write 0xA5.
- o_TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each bit 4 cycles.
- o_busy high for exactly 44 cycles.
REQ-032 Odd parity, two stop bits: Prescale=1, PAR_TYP=1, STP2=1, write 0x00.
- Line: 0, eight 0s, parity 1, 1, 1.
- 12 cycles busy.
REQ-033 Back-to-back: write 0x11, 0x22, 0x33 on consecutive cycles.
- Three frames with no idle cycle between them.
- o_count goes 1,1,2 then drains to 0.
REQ-034 Overflow (FIFO_DEPTH=4): during an active frame, hold i_Data_Valid for 5 cycles with 0x01..0x05.
- o_ready drops after the 4th accept.
- 0x05 is never transmitted.
REQ-035 Reset mid-frame: assert RST during the DATA state of 0xFF.
- o_TX_OUT=1, o_busy=0, o_count=0 immediately.
- After release, the line stays idle high.
REQ-036 Build without UART_TX_FIFO_EN: writing a second word during a frame is refused (o_ready=0); the first held word transmits next.
